wb_arb2: RTL and testbench

WB_ARB2 -- requirements
Module: wb_arb2

---
 rtl/wb_arb2.sv | 135 +++++++++++++
 tb/tb_wb_arb2.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb2.sv
// Two-master Wishbone arbiter (CPU + display DMA) in front of one slave RAM port.
// Round-robin on ties, grant held for the whole cyc, with a stalled-strobe watchdog.
module wb_arb2 #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    input  logic        m0_instr_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    output logic        s_instr_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  grant_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t        state_q, state_d;
    logic          last_gnt_q, last_gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    grant_q;
    logic [1:0]    rst_sync_q;
    logic          run;
    logic          g0, g1, stb_sel, cyc_sel, timeout;

    assign run = rst_sync_q[1];
    assign g0  = (state_q == GNT0);
    assign g1  = (state_q == GNT1);

    // Assertion is immediate; release reaches the FSM only after two edges.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) rst_sync_q <= 2'b00;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign stb_sel = (g0 & m0_stb_i) | (g1 & m1_stb_i);
    assign cyc_sel = (g0 & m0_cyc_i) | (g1 & m1_cyc_i);
    // A slave ack landing on the deadline cycle still wins.
    assign timeout = (g0 | g1) && (cnt_q == TO_V) && !s_ack_i;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        unique case (state_q)
            IDLE: if (run) begin
                if (m0_cyc_i && (!m1_cyc_i || last_gnt_q)) begin
                    state_d    = GNT0;
                    last_gnt_d = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d    = GNT1;
                    last_gnt_d = 1'b1;
                end
            end
            GNT0:    if (!m0_cyc_i || timeout) state_d = IDLE;
            GNT1:    if (!m1_cyc_i || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (state_d != state_q || s_ack_i || !stb_sel) cnt_d = '0;
        else if (cnt_q != '1)                           cnt_d = cnt_q + 1'b1;
        else                                            cnt_d = cnt_q;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            cnt_q      <= '0;
            grant_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            grant_q    <= {state_d == GNT1, state_d == GNT0};
        end
    end

    assign grant_o = grant_q;

    always_comb begin
        s_adr_o = 32'h0;
        s_dat_o = 32'h0;
        s_sel_o = 4'h0;
        s_we_o  = 1'b0;
        if (g0) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
        end else if (g1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
        end
    end

    assign s_stb_o   = stb_sel & ~timeout;
    assign s_cyc_o   = cyc_sel & ~timeout;
    assign s_instr_o = g0 & m0_instr_i;

    assign m0_ack_o = g0 & s_ack_i;
    assign m1_ack_o = g1 & s_ack_i;
    assign m0_err_o = g0 & timeout;
    assign m1_err_o = g1 & timeout;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
endmodule

// File: tb/tb_wb_arb2.sv
// Directed bench for wb_arb2 with a one-wait-state RAM slave model.
module tb_wb_arb2;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m0_stb, m0_cyc, m0_instr, m1_we, m1_stb, m1_cyc;
    logic [31:0] m0_rd, m1_rd;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] s_adr, s_wdat;
    logic [3:0]  s_sel;
    logic        s_we, s_stb, s_cyc, s_instr;
    logic [1:0]  grant;
    logic        ack_q = 1'b0;
    logic [31:0] rdat_q = 32'h0;
    logic        ack_en, ack_force;
    logic        s_ack;
    logic [31:0] mem [0:63];
    int          vec = 0;
    int          miss = 0;

    always #5 clk = ~clk;
    assign s_ack = ack_q | ack_force;

    wb_arb2 #(.TIMEOUT(8)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
        .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_instr_i(m0_instr),
        .m0_dat_o(m0_rd), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
        .m1_dat_o(m1_rd), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we),
        .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_instr_o(s_instr),
        .s_dat_i(rdat_q), .s_ack_i(s_ack), .grant_o(grant)
    );

    // Slave: accepts a strobe, commits writes and acks on the following cycle.
    always @(posedge clk) begin
        if (ack_en && s_stb && s_cyc && !ack_q) begin
            ack_q  <= 1'b1;
            rdat_q <= mem[s_adr[7:2]];
            if (s_we)
                for (int b = 0; b < 4; b++)
                    if (s_sel[b]) mem[s_adr[7:2]][8*b +: 8] <= s_wdat[8*b +: 8];
        end else begin
            ack_q <= 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m0(input logic cyc, stb, we, input logic [31:0] adr, dat, input logic instr);
        m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat = dat;
        m0_sel = 4'hF; m0_instr = instr;
    endtask

    task automatic drive_m1(input logic cyc, stb, we, input logic [31:0] adr, dat);
        m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat = dat; m1_sel = 4'hF;
    endtask

    task automatic wait_any_grant(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (grant != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b0; ack_en = 1'b1; ack_force = 1'b0;
        drive_m0(1, 0, 0, 32'h0, 32'h0, 0);
        drive_m1(1, 0, 0, 32'h0, 32'h0);
        #2;
        vec++; if ({grant, s_stb, s_cyc, m0_ack, m0_err, m1_ack, m1_err} !== 8'h00) begin
            miss++; $display("FAIL reset_outputs got %b want 00000000",
                             {grant, s_stb, s_cyc, m0_ack, m0_err, m1_ack, m1_err});
        end
        step(); step();
        rst_n = 1'b1;
        step();
        vec++; if (grant !== 2'b00) begin
            miss++; $display("FAIL reset_sync_first_edge grant got %b want 00", grant);
        end
        wait_any_grant(6, ok);
        vec++; if (!ok || grant !== 2'b01) begin
            miss++; $display("FAIL first_tie grant got %b want 01", grant);
        end
    endtask

    task automatic test_round_robin();
        vec++; if (s_cyc !== 1'b1 || s_stb !== 1'b0) begin
            miss++; $display("FAIL gnt0_mirror cyc/stb got %b%b want 10", s_cyc, s_stb);
        end
        m0_cyc = 1'b0;
        step();
        vec++; if (grant !== 2'b00) begin
            miss++; $display("FAIL idle_gap grant got %b want 00", grant);
        end
        step();
        vec++; if (grant !== 2'b10) begin
            miss++; $display("FAIL rr_second grant got %b want 10", grant);
        end
        m1_cyc = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        bit ok;
        bit bad0 = 1'b0;
        drive_m0(1, 1, 1, 32'h10, 32'hDEADBEEF, 1);
        wait_any_grant(4, ok);
        vec++; if (!ok || grant !== 2'b01 || s_adr !== 32'h10 || s_wdat !== 32'hDEADBEEF
                   || s_we !== 1'b1 || s_sel !== 4'hF || s_instr !== 1'b1) begin
            miss++; $display("FAIL m0_write_mirror grant %b adr %h dat %h we %b instr %b", grant, s_adr, s_wdat, s_we, s_instr);
        end
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (m0_ack) ok = 1'b1; else step();
        end
        vec++; if (!ok) begin miss++; $display("FAIL m0_write_ack got none want ack"); end
        drive_m0(0, 0, 0, 32'h0, 32'h0, 1);
        drive_m1(1, 1, 0, 32'h10, 32'h0);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            if (grant == 2'b10 && m0_ack) bad0 = 1'b1;
            if (grant == 2'b10 && s_instr) bad0 = 1'b1;
            if (m1_ack) ok = 1'b1;
        end
        vec++; if (!ok || m1_rd !== 32'hDEADBEEF || m0_rd !== 32'hDEADBEEF) begin
            miss++; $display("FAIL m1_readback got %h/%h want deadbeef", m1_rd, m0_rd);
        end
        vec++; if (bad0) begin miss++; $display("FAIL m0_quiet_in_gnt1 got ack/instr want 0"); end
        m1_cyc = 1'b0; m1_stb = 1'b0;
        step();
    endtask

    task automatic test_hold();
        int  acks = 0;
        bit  bad = 1'b0;
        drive_m0(1, 1, 0, 32'h10, 32'h0, 0);
        drive_m1(1, 1, 0, 32'h10, 32'h0);
        for (int i = 0; i < 40 && acks < 4; i++) begin
            step();
            if (grant !== 2'b01 || m1_ack) bad = 1'b1;
            if (m0_ack) acks++;
        end
        vec++; if (acks != 4 || bad) begin
            miss++; $display("FAIL hold_grant acks got %0d want 4 (stray=%b)", acks, bad);
        end
        m0_cyc = 1'b0; m0_stb = 1'b0;
        step();
        vec++; if (grant !== 2'b00) begin miss++; $display("FAIL hold_release grant got %b want 00", grant); end
        step();
        vec++; if (grant !== 2'b10) begin miss++; $display("FAIL hold_m1_next grant got %b want 10", grant); end
        m1_cyc = 1'b0; m1_stb = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        bit ok;
        bit early = 1'b0;
        ack_en = 1'b0;
        drive_m1(1, 1, 0, 32'h40, 32'h0);
        wait_any_grant(4, ok);
        for (int k = 0; k < 8; k++) begin
            if (m1_err || m0_err || s_stb !== 1'b1) early = 1'b1;
            step();
        end
        vec++; if (!ok || early) begin miss++; $display("FAIL timeout_early err got early pulse (ok=%b)", ok); end
        vec++; if (m1_err !== 1'b1 || m0_err !== 1'b0 || s_stb !== 1'b0 || s_cyc !== 1'b0) begin
            miss++; $display("FAIL timeout_pulse err1/err0/stb/cyc got %b%b%b%b want 1000", m1_err, m0_err, s_stb, s_cyc);
        end
        step();
        vec++; if (grant !== 2'b00 || m1_err !== 1'b0) begin
            miss++; $display("FAIL timeout_idle grant %b err %b want 00/0", grant, m1_err);
        end
        step();
        vec++; if (grant !== 2'b10) begin miss++; $display("FAIL timeout_rearb grant got %b want 10", grant); end
        m1_cyc = 1'b0; m1_stb = 1'b0;
        step();
    endtask

    task automatic test_ack_at_deadline();
        bit ok;
        bit early = 1'b0;
        drive_m0(1, 1, 0, 32'h40, 32'h0, 0);
        wait_any_grant(4, ok);
        for (int k = 0; k < 8; k++) begin
            if (m0_err || m0_ack) early = 1'b1;
            step();
        end
        ack_force = 1'b1;
        #1;
        vec++; if (!ok || early || m0_ack !== 1'b1 || m0_err !== 1'b0 || s_stb !== 1'b1) begin
            miss++; $display("FAIL ack_wins ack/err/stb got %b%b%b want 101", m0_ack, m0_err, s_stb);
        end
        step();
        ack_force = 1'b0;
        #1;
        vec++; if (grant !== 2'b01 || m0_err !== 1'b0) begin
            miss++; $display("FAIL ack_wins_after grant %b err %b want 01/0", grant, m0_err);
        end
        m0_cyc = 1'b0; m0_stb = 1'b0;
        step();
        ack_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        drive_m1(1, 1, 1, 32'h10, 32'hCAFEF00D);
        wait_any_grant(4, ok);
        vec++; if (!ok || grant !== 2'b10) begin miss++; $display("FAIL mid_grant got %b want 10", grant); end
        rst_n = 1'b0;
        #1;
        vec++; if ({grant, s_stb, s_cyc, s_we, m0_ack, m0_err, m1_ack, m1_err} !== 9'h000) begin
            miss++; $display("FAIL mid_reset_outputs got %b want 000000000",
                             {grant, s_stb, s_cyc, s_we, m0_ack, m0_err, m1_ack, m1_err});
        end
        step(); step();
        vec++; if (mem[4] !== 32'hDEADBEEF) begin
            miss++; $display("FAIL mid_reset_ram got %h want deadbeef", mem[4]);
        end
        drive_m0(1, 0, 0, 32'h0, 32'h0, 0);
        drive_m1(1, 0, 0, 32'h0, 32'h0);
        rst_n = 1'b1;
        wait_any_grant(6, ok);
        vec++; if (!ok || grant !== 2'b01) begin miss++; $display("FAIL post_reset_tie got %b want 01", grant); end
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write_read();
        test_hold();
        test_timeout();
        test_ack_at_deadline();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
